// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control sequencer for the MIPS datapath.
// Five-state FSM (IF, ID, EXE, MEM, WB) that produces PC/IR/register-file
// write strobes, next-PC selection, memory requests and the ALU/operand
// decode for the instruction currently held in the IR.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   OpCode, funct         IR[31:26], IR[5:0]
//   Zero                  ALU zero flag, looked at only in EXE
//   mem_ready             acknowledge from the shared memory port
//   PCWr, IRWr, NPCOp     PC write, IR write, next-PC source
//   MemR, MemW            memory read / write requests
//   RegW, RegDst, WDSel   register-file write enable, destination, data select
//   Alusrc, shift, ExtOp  ALU operand B select, shamt select, immediate extension
//   Aluctrl               ALU operation
//   state                 current FSM state (debug)
//   illegal               one-cycle pulse in ID on an unsupported instruction
//   instr_cnt             retired-instruction counter (wraps)
//
// Memory handshake: MemR/MemW act as "valid" and mem_ready as "ready". A
// request is raised combinationally from the state, is held unchanged while
// mem_ready is 0, and is accepted on the rising edge where both are 1; the
// FSM leaves the requesting state on that same edge. mem_ready is ignored in
// ID, EXE and WB.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       funct,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWr,
  output logic             IRWr,
  output logic [1:0]       NPCOp,
  output logic             MemR,
  output logic             MemW,
  output logic             RegW,
  output logic [1:0]       RegDst,
  output logic [1:0]       WDSel,
  output logic             Alusrc,
  output logic             shift,
  output logic [1:0]       ExtOp,
  output logic [4:0]       Aluctrl,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [1:0] EXT_ZERO    = 2'd0;
  localparam logic [1:0] EXT_SIGNED  = 2'd1;
  localparam logic [1:0] EXT_HIGHPOS = 2'd2;

  localparam logic [4:0] ALUOp_NOP  = 5'd0;
  localparam logic [4:0] ALUOp_ADDU = 5'd1;
  localparam logic [4:0] ALUOp_ADD  = 5'd2;
  localparam logic [4:0] ALUOp_SUBU = 5'd3;
  localparam logic [4:0] ALUOp_SUB  = 5'd4;
  localparam logic [4:0] ALUOp_AND  = 5'd5;
  localparam logic [4:0] ALUOp_OR   = 5'd6;
  localparam logic [4:0] ALUOp_SLT  = 5'd7;
  localparam logic [4:0] ALUOp_SLL  = 5'd8;
  localparam logic [4:0] ALUOp_SRL  = 5'd9;
  localparam logic [4:0] ALUOp_SRA  = 5'd10;
  localparam logic [4:0] ALUOp_LUI  = 5'd11;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t cur_state, nxt_state;

  // ---------------- instruction decode ----------------
  logic       legal, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr;
  logic       d_alusrc, d_shift;
  logic [1:0] d_ext, d_regdst, d_wdsel;
  logic [4:0] d_alu;

  always_comb begin
    legal = 1'b1;
    is_lw = 1'b0; is_sw = 1'b0; is_beq = 1'b0; is_bne = 1'b0;
    is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0;
    d_alusrc = 1'b0;
    d_shift  = 1'b0;
    d_ext    = EXT_ZERO;
    d_regdst = 2'b00;
    d_wdsel  = 2'b00;
    d_alu    = ALUOp_NOP;
    case (OpCode)
      6'b000000: begin
        d_regdst = 2'b01;
        case (funct)
          6'b000000: begin d_shift = 1'b1; d_alu = ALUOp_SLL; end
          6'b000010: begin d_shift = 1'b1; d_alu = ALUOp_SRL; end
          6'b000011: begin d_shift = 1'b1; d_alu = ALUOp_SRA; end
          6'b100000: d_alu = ALUOp_ADD;
          6'b100001: d_alu = ALUOp_ADDU;
          6'b100010: d_alu = ALUOp_SUB;
          6'b100011: d_alu = ALUOp_SUBU;
          6'b100100: d_alu = ALUOp_AND;
          6'b100101: d_alu = ALUOp_OR;
          6'b101010: d_alu = ALUOp_SLT;
          6'b001000: begin is_jr = 1'b1; d_regdst = 2'b00; end
          default:   begin legal = 1'b0; d_regdst = 2'b00; end
        endcase
      end
      6'b001101: begin d_alusrc = 1'b1; d_ext = EXT_ZERO;    d_alu = ALUOp_OR;   end
      6'b001000: begin d_alusrc = 1'b1; d_ext = EXT_SIGNED;  d_alu = ALUOp_ADD;  end
      6'b001010: begin d_alusrc = 1'b1; d_ext = EXT_SIGNED;  d_alu = ALUOp_SLT;  end
      6'b001111: begin d_alusrc = 1'b1; d_ext = EXT_HIGHPOS; d_alu = ALUOp_LUI;  end
      6'b100011: begin
        is_lw = 1'b1; d_alusrc = 1'b1; d_ext = EXT_SIGNED; d_alu = ALUOp_ADDU;
        d_wdsel = 2'b01;
      end
      6'b101011: begin is_sw = 1'b1; d_alusrc = 1'b1; d_ext = EXT_SIGNED; d_alu = ALUOp_ADDU; end
      6'b000100: begin is_beq = 1'b1; d_ext = EXT_SIGNED; d_alu = ALUOp_SUB; end
      6'b000101: begin is_bne = 1'b1; d_ext = EXT_SIGNED; d_alu = ALUOp_SUB; end
      6'b000010: is_j = 1'b1;
      6'b000011: begin is_jal = 1'b1; d_regdst = 2'b10; d_wdsel = 2'b10; end
      default:   legal = 1'b0;
    endcase
  end

  // Decode is only meaningful once the IR holds the fetched word.
  logic dec_on;
  assign dec_on = (cur_state == S_ID) || (cur_state == S_EXE) ||
                  (cur_state == S_MEM) || (cur_state == S_WB);

  assign Alusrc  = dec_on & d_alusrc;
  assign shift   = dec_on & d_shift;
  assign ExtOp   = dec_on ? d_ext    : 2'b00;
  assign Aluctrl = dec_on ? d_alu    : ALUOp_NOP;
  assign RegDst  = dec_on ? d_regdst : 2'b00;
  assign WDSel   = dec_on ? d_wdsel  : 2'b00;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= S_IF;
    else        cur_state <= nxt_state;
  end

  logic       pc_wr, ir_wr, mem_r, mem_w, reg_w, ill;
  logic [1:0] npc;

  always_comb begin
    nxt_state = S_IF;
    pc_wr = 1'b0; ir_wr = 1'b0; mem_r = 1'b0; mem_w = 1'b0;
    reg_w = 1'b0; ill = 1'b0;
    npc   = NPC_PC4;
    case (cur_state)
      S_IF: begin
        mem_r = 1'b1;
        if (mem_ready) begin
          ir_wr = 1'b1; pc_wr = 1'b1; nxt_state = S_ID;
        end else begin
          nxt_state = S_IF;
        end
      end
      S_ID: begin
        if (is_j || is_jal) begin
          pc_wr = 1'b1; npc = NPC_J; reg_w = is_jal;
        end else if (is_jr) begin
          pc_wr = 1'b1; npc = NPC_JR;
        end else if (!legal) begin
          ill = 1'b1;
        end else begin
          nxt_state = S_EXE;
        end
      end
      S_EXE: begin
        if (is_beq || is_bne) begin
          npc   = NPC_BR;
          pc_wr = is_beq ? Zero : !Zero;
        end else if (is_lw || is_sw) begin
          nxt_state = S_MEM;
        end else begin
          nxt_state = S_WB;
        end
      end
      S_MEM: begin
        mem_r = is_lw;
        mem_w = is_sw;
        if (!mem_ready && (is_lw || is_sw)) nxt_state = S_MEM;
        else if (is_lw)                     nxt_state = S_WB;
        else                                nxt_state = S_IF;
      end
      S_WB: reg_w = 1'b1;
      default: nxt_state = S_IF;
    endcase
  end

  // Strobes are forced low while reset is held so nothing is written.
  assign PCWr    = rst_n & pc_wr;
  assign IRWr    = rst_n & ir_wr;
  assign MemR    = rst_n & mem_r;
  assign MemW    = rst_n & mem_w;
  assign RegW    = rst_n & reg_w;
  assign illegal = rst_n & ill;
  assign NPCOp   = npc;
  assign state   = cur_state;

  // An instruction retires on any edge that returns to IF from elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      instr_cnt <= '0;
    else if ((nxt_state == S_IF) && (cur_state != S_IF))
      instr_cnt <= instr_cnt + CNT_W'(1);
  end

endmodule
